// File: rtl/ram_population_pp_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_population_pp_if
// Purpose  : Bundles the write, read, swap and status signals of the
//            ping-pong population memory into one connection.
// Modports : master - producer/consumer side (drives strobes, sees status)
//            slave  - memory side (ram_population_pp)
// Signals  : wr_en/wr_addr/wr_data      next-generation write port
//            rd_en/rd_addr              current-generation read request
//            rd_data/rd_valid/rd_perr   registered read response
//            swap_req/swap_ack          bank exchange handshake
//            ready/wr_cnt/wr_full/gen_cnt/addr_err  status
// Revision : 1.0 - initial release
// ============================================================================
interface ram_population_pp_if #(
   parameter int DATA_WDTH = 320,
   parameter int COL_BITS  = 8,
   parameter int GEN_BITS  = 16
);
   logic                 wr_en;
   logic [COL_BITS-1:0]  wr_addr;
   logic [DATA_WDTH-1:0] wr_data;
   logic                 rd_en;
   logic [COL_BITS-1:0]  rd_addr;
   logic [DATA_WDTH-1:0] rd_data;
   logic                 rd_valid;
   logic                 rd_perr;
   logic                 swap_req;
   logic                 swap_ack;
   logic                 ready;
   logic [COL_BITS:0]    wr_cnt;
   logic                 wr_full;
   logic [GEN_BITS-1:0]  gen_cnt;
   logic                 addr_err;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req,
      input  rd_data, rd_valid, rd_perr, swap_ack, ready,
             wr_cnt, wr_full, gen_cnt, addr_err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr, swap_req,
      output rd_data, rd_valid, rd_perr, swap_ack, ready,
             wr_cnt, wr_full, gen_cnt, addr_err
   );
endinterface
`default_nettype wire

// File: rtl/ram_population_pp.sv
`default_nettype none
// ============================================================================
// Module   : ram_population_pp
// Purpose  : Double-buffered population memory. Reads come from the active
//            bank (bank_sel), writes build the next generation in the shadow
//            bank (~bank_sel); an accepted swap exchanges the two. After
//            reset both banks are cleared one row per cycle before ready.
// Ports    : clk    - clock, rising edge
//            rst_n  - synchronous active-low reset
//            bus    - ram_population_pp_if.slave (write/read/swap/status)
// Options  : RAM_POP_PARITY_EN - store an even-parity bit per row and flag
//            mismatches on rd_perr; when undefined rd_perr is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module ram_population_pp #(
   parameter int DATA_WDTH      = 320,
   parameter int COL            = 200,
   parameter int COL_BITS       = 8,
   parameter int GEN_BITS       = 16,
   parameter int SWAP_WHEN_FULL = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   ram_population_pp_if.slave bus
);
   localparam logic [COL_BITS:0] c_col  = COL[COL_BITS:0];
   localparam logic [COL_BITS:0] c_last = c_col - 1'b1;

   localparam logic [0:0] c_st_init = 1'b0;
   localparam logic [0:0] c_st_run  = 1'b1;

   logic [DATA_WDTH-1:0] r_mem [2][COL];

   logic [0:0]           r_state;
   logic [COL_BITS-1:0]  r_clr_ptr;
   logic                 r_bank_sel;
   logic [DATA_WDTH-1:0] r_rd_data;
   logic                 r_rd_valid;
   logic                 r_swap_ack;
   logic                 r_ready;
   logic [COL_BITS:0]    r_wr_cnt;
   logic [GEN_BITS-1:0]  r_gen_cnt;
   logic                 r_addr_err;

   logic                 w_run;
   logic                 w_clr;
   logic                 w_wr_in_range;
   logic                 w_rd_in_range;
   logic                 w_wr_ok;
   logic                 w_wr_bad;
   logic                 w_rd_bad;
   logic                 w_wr_full;
   logic                 w_swap_ok;
   logic                 w_swap;
   logic [DATA_WDTH-1:0] w_rd_row;

   assign w_run         = (r_state == c_st_run);
   assign w_clr         = rst_n & (r_state == c_st_init);
   assign w_wr_in_range = ({1'b0, bus.wr_addr} < c_col);
   assign w_rd_in_range = ({1'b0, bus.rd_addr} < c_col);
   assign w_wr_ok       = rst_n & w_run & bus.wr_en & w_wr_in_range;
   assign w_wr_bad      = w_run & bus.wr_en & ~w_wr_in_range;
   assign w_rd_bad      = w_run & bus.rd_en & ~w_rd_in_range;
   assign w_wr_full     = (r_wr_cnt == c_col);
   assign w_swap        = w_run & bus.swap_req & w_swap_ok;
   assign w_rd_row      = r_mem[r_bank_sel][bus.rd_addr];

   generate
      if (SWAP_WHEN_FULL != 0) begin : g_swap_full
         assign w_swap_ok = w_wr_full;
      end else begin : g_swap_any
         assign w_swap_ok = 1'b1;
      end
   endgenerate

   // Storage has no reset of its own; the INIT sweep clears it so the array
   // can still map onto RAM macros.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_mem[0][r_clr_ptr] <= '0;
         r_mem[1][r_clr_ptr] <= '0;
      end else if (w_wr_ok) begin
         // Uses the pre-swap bank_sel, so a write coinciding with a swap
         // lands in the bank that becomes readable.
         r_mem[~r_bank_sel][bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= c_st_init;
         r_clr_ptr  <= '0;
         r_bank_sel <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_swap_ack <= 1'b0;
         r_ready    <= 1'b0;
         r_wr_cnt   <= '0;
         r_gen_cnt  <= '0;
         r_addr_err <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         r_swap_ack <= 1'b0;
         r_addr_err <= 1'b0;
         case (r_state)
            c_st_init: begin
               r_clr_ptr <= r_clr_ptr + 1'b1;
               if ({1'b0, r_clr_ptr} == c_last) begin
                  r_state <= c_st_run;
                  r_ready <= 1'b1;
               end
            end
            c_st_run: begin
               if (bus.rd_en) begin
                  r_rd_valid <= 1'b1;
                  r_rd_data  <= w_rd_in_range ? w_rd_row : '0;
               end
               // Simultaneous write and read errors merge into one pulse.
               r_addr_err <= w_wr_bad | w_rd_bad;
               if (w_swap) begin
                  r_bank_sel <= ~r_bank_sel;
                  r_wr_cnt   <= '0;
                  r_gen_cnt  <= r_gen_cnt + 1'b1;
                  r_swap_ack <= 1'b1;
               end else if (w_wr_ok && !w_wr_full) begin
                  r_wr_cnt <= r_wr_cnt + 1'b1;
               end
            end
            default: r_state <= c_st_init;
         endcase
      end
   end

`ifdef RAM_POP_PARITY_EN
   logic r_par [2][COL];
   logic r_rd_perr;
   logic w_rd_par;

   assign w_rd_par = r_par[r_bank_sel][bus.rd_addr];

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_par[0][r_clr_ptr] <= 1'b0;
         r_par[1][r_clr_ptr] <= 1'b0;
      end else if (w_wr_ok) begin
         r_par[~r_bank_sel][bus.wr_addr] <= ^bus.wr_data;
      end
   end

   // Travels with rd_data: updated only on an accepted read, held otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_perr <= 1'b0;
      end else if (w_run && bus.rd_en) begin
         r_rd_perr <= w_rd_in_range && ((^w_rd_row) != w_rd_par);
      end
   end

   assign bus.rd_perr = r_rd_perr;
`else
   assign bus.rd_perr = 1'b0;
`endif

   assign bus.rd_data  = r_rd_data;
   assign bus.rd_valid = r_rd_valid;
   assign bus.swap_ack = r_swap_ack;
   assign bus.ready    = r_ready;
   assign bus.wr_cnt   = r_wr_cnt;
   assign bus.wr_full  = w_wr_full;
   assign bus.gen_cnt  = r_gen_cnt;
   assign bus.addr_err = r_addr_err;
endmodule
`default_nettype wire
